multiplicador_mantiza_secuencial: RTL and testbench



---
 rtl/multiplicador_mantiza_secuencial_pkg.sv | 31 +++
 rtl/multiplicador_mantiza_secuencial_if.sv | 31 +++
 rtl/multiplicador_mantiza_secuencial_normalizador.sv | 55 +++++
 rtl/multiplicador_mantiza_secuencial.sv | 122 ++++++++++++
 tb/tb_multiplicador_mantiza_secuencial.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/multiplicador_mantiza_secuencial_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : multiplicador_pkg
//  Purpose   : FSM encoding, counter sizing and rounding-mode constants for
//              the sequential mantissa multiplier. Optional macro:
//              MULTIPLICADOR_REDONDEO_EN.
//  Revision  : 1.0 - initial release
// ============================================================================
package multiplicador_pkg;

    localparam logic [1:0] REPOSO    = 2'd0;
    localparam logic [1:0] CALCULO   = 2'd1;
    localparam logic [1:0] NORMALIZA = 2'd2;
    localparam logic [1:0] SALIDA    = 2'd3;

    localparam logic c_MODO_TRUNCA       = 1'b0;
    localparam logic c_MODO_REDONDEO_PAR = 1'b1;

`ifdef MULTIPLICADOR_REDONDEO_EN
    localparam logic c_MODO_REDONDEO = c_MODO_REDONDEO_PAR;
`else
    localparam logic c_MODO_REDONDEO = c_MODO_TRUNCA;
`endif

    // Counter must hold values 0..N+1 (it steps once past the last iteration).
    function automatic int f_nb_contador(input int nb_mantiza);
        return $clog2(nb_mantiza + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multiplicador_mantiza_secuencial_if.sv
`default_nettype none
// ============================================================================
//  Interface : multiplicador_mantiza_secuencial_if
//  Purpose   : Operand/result valid-ready bus of the sequential multiplier.
//  Revision  : 1.0 - initial release
// ============================================================================
interface multiplicador_mantiza_secuencial_if #(
    parameter int NB_MANTIZA = 8
) ();
    logic                  i_valid;
    logic                  o_ready;
    logic [NB_MANTIZA-1:0] i_mantiza_1;
    logic [NB_MANTIZA-1:0] i_mantiza_2;
    logic                  o_valid;
    logic                  i_ready;
    logic [NB_MANTIZA-1:0] o_mantiza;
    logic                  o_aviso_exponente;

    // Environment side: supplies operands and consumes results.
    modport master (
        output i_valid, i_mantiza_1, i_mantiza_2, i_ready,
        input  o_ready, o_valid, o_mantiza, o_aviso_exponente
    );

    // Multiplier side.
    modport slave (
        input  i_valid, i_mantiza_1, i_mantiza_2, i_ready,
        output o_ready, o_valid, o_mantiza, o_aviso_exponente
    );
endinterface
`default_nettype wire

// File: rtl/multiplicador_mantiza_secuencial_normalizador.sv
`default_nettype none
// ============================================================================
//  Module    : normalizador_mantiza
//  Purpose   : Combinational normalisation of the 2N+2-bit product into a
//              stored mantissa plus exponent-increment flag. Round-to-nearest-
//              even is built only when MULTIPLICADOR_REDONDEO_EN is defined.
//  Revision  : 1.0 - initial release
// ============================================================================
module normalizador_mantiza
    import multiplicador_pkg::*;
#(
    parameter int NB_MANTIZA = 8
) (
    input  wire logic [2*NB_MANTIZA+1:0] i_producto,
    output logic      [NB_MANTIZA-1:0]   o_mantiza,
    output logic                         o_aviso_exponente
);
    localparam int N = NB_MANTIZA;

    logic         w_msb;
    logic [N-1:0] w_mant_trunc;

    assign w_msb        = i_producto[2*N+1];
    assign w_mant_trunc = w_msb ? i_producto[2*N:N+1] : i_producto[2*N-1:N];

`ifdef MULTIPLICADOR_REDONDEO_EN
    logic         w_guarda;
    logic         w_sticky;
    logic         w_incrementa;
    logic [N:0]   w_mant_red;

    assign w_guarda     = w_msb ? i_producto[N]        : i_producto[N-1];
    assign w_sticky     = w_msb ? (|i_producto[N-1:0]) : (|i_producto[N-2:0]);
    assign w_incrementa = w_guarda & (w_sticky | w_mant_trunc[0]);
    assign w_mant_red   = {1'b0, w_mant_trunc} + {{N{1'b0}}, w_incrementa};

    // A carry out means the product rounded up to exactly 2.0.
    always_comb begin
        o_mantiza         = w_mant_red[N-1:0];
        o_aviso_exponente = w_msb;
        if (w_mant_red[N]) begin
            o_mantiza         = '0;
            o_aviso_exponente = 1'b1;
        end
    end
`else
    logic w_unused_descartados;

    assign w_unused_descartados = ^i_producto[N-1:0];
    assign o_mantiza            = w_mant_trunc;
    assign o_aviso_exponente    = w_msb;
`endif

endmodule
`default_nettype wire

// File: rtl/multiplicador_mantiza_secuencial.sv
`default_nettype none
// ============================================================================
//  Module    : multiplicador_mantiza_secuencial
//  Purpose   : Radix-2 shift-add mantissa multiplier with hidden 1, valid/ready
//              handshake on both sides; optional rounding via
//              MULTIPLICADOR_REDONDEO_EN. NB_MANTIZA legal range is 4..32.
//  Revision  : 1.0 - initial release
// ============================================================================
module multiplicador_mantiza_secuencial
    import multiplicador_pkg::*;
#(
    parameter int NB_MANTIZA = 8
) (
    input  wire logic                    i_clk,
    input  wire logic                    i_rst,
    multiplicador_mantiza_secuencial_if.slave bus
);
    localparam int N           = NB_MANTIZA;
    localparam int NB_CONTADOR = f_nb_contador(NB_MANTIZA);
    localparam int NB_PRODUCTO = 2 * N + 2;

    localparam logic [NB_CONTADOR-1:0] c_CONTADOR_FIN = NB_CONTADOR'(N);

    logic [1:0]             state_q,         state_d;
    logic [NB_CONTADOR-1:0] contador_q,      contador_d;
    logic [NB_PRODUCTO-1:0] acumulador_q,    acumulador_d;
    logic [NB_PRODUCTO-1:0] multiplicando_q, multiplicando_d;
    logic [N:0]             multiplicador_q, multiplicador_d;
    logic [N-1:0]           mantiza_q,       mantiza_d;
    logic                   aviso_q,         aviso_d;
    logic                   valid_q,         valid_d;

    logic [N-1:0]           w_mantiza_norm;
    logic                   w_aviso_norm;

    normalizador_mantiza #(
        .NB_MANTIZA (NB_MANTIZA)
    ) u_normalizador (
        .i_producto        (acumulador_q),
        .o_mantiza         (w_mantiza_norm),
        .o_aviso_exponente (w_aviso_norm)
    );

    always_comb begin
        state_d         = state_q;
        contador_d      = contador_q;
        acumulador_d    = acumulador_q;
        multiplicando_d = multiplicando_q;
        multiplicador_d = multiplicador_q;
        mantiza_d       = mantiza_q;
        aviso_d         = aviso_q;
        valid_d         = valid_q;

        case (state_q)
            REPOSO: begin
                if (bus.i_valid) begin
                    multiplicando_d = {{(N+1){1'b0}}, 1'b1, bus.i_mantiza_1};
                    multiplicador_d = {1'b1, bus.i_mantiza_2};
                    acumulador_d    = '0;
                    contador_d      = '0;
                    state_d         = CALCULO;
                end
            end
            CALCULO: begin
                if (multiplicador_q[0]) begin
                    acumulador_d = acumulador_q + multiplicando_q;
                end
                multiplicando_d = multiplicando_q << 1;
                multiplicador_d = multiplicador_q >> 1;
                contador_d      = contador_q + 1'b1;
                if (contador_q == c_CONTADOR_FIN) begin
                    state_d = NORMALIZA;
                end
            end
            NORMALIZA: begin
                mantiza_d = w_mantiza_norm;
                aviso_d   = w_aviso_norm;
                valid_d   = 1'b1;
                state_d   = SALIDA;
            end
            SALIDA: begin
                // Outputs stay frozen until the consumer takes them.
                if (bus.i_ready) begin
                    valid_d = 1'b0;
                    state_d = REPOSO;
                end
            end
            default: begin
                state_d = REPOSO;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q         <= REPOSO;
            contador_q      <= '0;
            acumulador_q    <= '0;
            multiplicando_q <= '0;
            multiplicador_q <= '0;
            mantiza_q       <= '0;
            aviso_q         <= 1'b0;
            valid_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            contador_q      <= contador_d;
            acumulador_q    <= acumulador_d;
            multiplicando_q <= multiplicando_d;
            multiplicador_q <= multiplicador_d;
            mantiza_q       <= mantiza_d;
            aviso_q         <= aviso_d;
            valid_q         <= valid_d;
        end
    end

    assign bus.o_ready           = (state_q == REPOSO);
    assign bus.o_valid           = valid_q;
    assign bus.o_mantiza         = mantiza_q;
    assign bus.o_aviso_exponente = aviso_q;

endmodule
`default_nettype wire

// File: tb/tb_multiplicador_mantiza_secuencial.sv
`default_nettype none
// ============================================================================
//  Module    : tb_multiplicador_mantiza_secuencial
//  Purpose   : Directed self-checking bench for the sequential mantissa
//              multiplier (N=8); expectations follow MULTIPLICADOR_REDONDEO_EN.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_multiplicador_mantiza_secuencial;

    localparam int NB_MANTIZA = 8;
    localparam int LATENCIA   = NB_MANTIZA + 2;
    localparam int MAX_ESPERA = 40;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    multiplicador_mantiza_secuencial_if #(.NB_MANTIZA(NB_MANTIZA)) bus ();

    multiplicador_mantiza_secuencial #(
        .NB_MANTIZA (NB_MANTIZA)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents operands, waits for the accept edge, then scrambles the inputs.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        n_vec++;
        if (bus.o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_before_op: got %b want 1", bus.o_ready);
        end
        bus.i_valid     = 1'b1;
        bus.i_mantiza_1 = a;
        bus.i_mantiza_2 = b;
        @(posedge clk);
        @(negedge clk);
        bus.i_valid     = 1'b0;
        bus.i_mantiza_1 = 8'($urandom);
        bus.i_mantiza_2 = 8'($urandom);
    endtask

    // Returns number of edges after the accept edge until o_valid (0 = timeout).
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int k = 1; k <= MAX_ESPERA; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.o_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.i_valid   = 1'b0;
        bus.i_ready   = 1'b0;
        bus.i_mantiza_1 = '0;
        bus.i_mantiza_2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (bus.o_valid !== 1'b0 || bus.o_mantiza !== 8'h00 ||
            bus.o_aviso_exponente !== 1'b0 || bus.o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: got valid=%b mant=%h aviso=%b ready=%b want 0/00/0/1",
                     bus.o_valid, bus.o_mantiza, bus.o_aviso_exponente, bus.o_ready);
        end
        // i_ready with nothing pending must be harmless.
        bus.i_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL idle_ready: got valid=%b ready=%b want 0/1", bus.o_valid, bus.o_ready);
        end
    endtask

    task automatic run_vector(input string nombre, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] exp_m, input logic exp_av);
        int lat;
        bus.i_ready = 1'b1;
        start_op(a, b);
        n_vec++;
        if (bus.o_ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy: got ready=%b want 0", nombre, bus.o_ready);
        end
        wait_valid(lat);
        n_vec++;
        if (lat !== LATENCIA) begin
            n_err++;
            $display("FAIL %s latency: got %0d want %0d", nombre, lat, LATENCIA);
        end
        n_vec++;
        if (bus.o_mantiza !== exp_m || bus.o_aviso_exponente !== exp_av) begin
            n_err++;
            $display("FAIL %s result: got mant=%h aviso=%b want mant=%h aviso=%b",
                     nombre, bus.o_mantiza, bus.o_aviso_exponente, exp_m, exp_av);
        end
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s handshake: got valid=%b ready=%b want 0/1",
                     nombre, bus.o_valid, bus.o_ready);
        end
    endtask

    task automatic test_vectors();
        run_vector("zero",      8'h00, 8'h00, 8'h00, 1'b0);
        run_vector("1p5x1p5",   8'h80, 8'h80, 8'h20, 1'b1);
        run_vector("max_x_max", 8'hFF, 8'hFF, 8'hFE, 1'b1);
        run_vector("max_x_one", 8'hFF, 8'h00, 8'hFF, 1'b0);
        run_vector("1p25sq",    8'h40, 8'h40, 8'h90, 1'b0);
`ifdef MULTIPLICADOR_REDONDEO_EN
        run_vector("tie_odd",   8'h01, 8'h80, 8'h82, 1'b0);
        run_vector("guard_stk", 8'h55, 8'hAA, 8'h1C, 1'b1);
`else
        run_vector("tie_odd",   8'h01, 8'h80, 8'h81, 1'b0);
        run_vector("guard_stk", 8'h55, 8'hAA, 8'h1B, 1'b1);
`endif
    endtask

    task automatic test_backpressure();
        int lat;
        bus.i_ready = 1'b0;
        start_op(8'h80, 8'h80);
        wait_valid(lat);
        n_vec++;
        if (lat !== LATENCIA) begin
            n_err++;
            $display("FAIL bp_latency: got %0d want %0d", lat, LATENCIA);
        end
        bus.i_valid     = 1'b1;
        bus.i_mantiza_1 = 8'hFF;
        bus.i_mantiza_2 = 8'h00;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_vec++;
            if (bus.o_valid !== 1'b1 || bus.o_mantiza !== 8'h20 ||
                bus.o_aviso_exponente !== 1'b1 || bus.o_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got valid=%b mant=%h aviso=%b ready=%b want 1/20/1/0",
                         c, bus.o_valid, bus.o_mantiza, bus.o_aviso_exponente, bus.o_ready);
            end
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: got valid=%b ready=%b want 0/1", bus.o_valid, bus.o_ready);
        end
        @(negedge clk);
        n_vec++;
        if (bus.o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_ignored_valid: got ready=%b want 1", bus.o_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        bit vio;
        bus.i_ready = 1'b1;
        start_op(8'hFF, 8'hFF);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid: got valid=%b ready=%b want 0/1", bus.o_valid, bus.o_ready);
        end
        vio = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.o_valid !== 1'b0) vio = 1'b1;
        end
        n_vec++;
        if (vio !== 1'b0) begin
            n_err++;
            $display("FAIL rst_abort: got spurious valid=%b want 0", vio);
        end
`ifdef MULTIPLICADOR_REDONDEO_EN
        run_vector("after_rst", 8'h01, 8'h80, 8'h82, 1'b0);
`else
        run_vector("after_rst", 8'h01, 8'h80, 8'h81, 1'b0);
`endif
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
